pipe_cu_hz: RTL and testbench

Parametrised pipelined-CPU control unit with hazard handling. It decodes the ID-stage instruction into datapath controls and resolves data hazards with forwarding selects and load-use interlocks. It also sequences a multi-cycle multiply (`mul`) by freezing the front end and keeps saturating stall counters. It replaces the purely combinational ID-stage decoder, sits in ID, and drives the PC, IF/ID, ID/EX and EX/MEM register enables.

---
 rtl/pipe_cu_pkg.sv | 56 +++++
 rtl/pipe_mdu_seq.sv | 53 +++++
 rtl/pipe_cu_hz.sv | 168 ++++++++++++++++
 tb/tb_pipe_cu_hz.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_cu_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, functs, ALU ops,
// forwarding selects and the multiply sequencer state.
package pipe_cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF     = 2'b00,
    FWD_EXALU  = 2'b01,
    FWD_MEMALU = 2'b10,
    FWD_MEMDAT = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/pipe_mdu_seq.sv
// Multi-cycle multiply sequencer: freezes the front end while mul occupies EX.
//   state    | meaning
//   MDU_IDLE | no multiply in flight, pipeline enables normal
//   MDU_BUSY | mul holding EX; front end frozen, bubbles into EX/MEM
module pipe_mdu_seq
  import pipe_cu_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] LOAD = CW'(MUL_LAT - 1);

  mdu_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MDU_IDLE: begin
        // a single-cycle multiply needs no freeze at all
        if (start && (MUL_LAT > 1)) begin
          state_n = MDU_BUSY;
          cnt_n   = LOAD;
        end
      end
      MDU_BUSY: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = MDU_IDLE;
      end
      default: state_n = MDU_IDLE;
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/pipe_cu_hz.sv
// ID-stage control unit: instruction decode, operand forwarding, load-use
// interlock, mul front-end freeze and saturating stall counters.
module pipe_cu_hz
  import pipe_cu_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic [RA_W-1:0]  rs,
  input  logic [RA_W-1:0]  rt,
  input  logic             z,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [RA_W-1:0]  ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [RA_W-1:0]  mrn,
  output logic             wreg,
  output logic             wmem,
  output logic             regrt,
  output logic             m2reg,
  output logic             shift,
  output logic             aluimm,
  output logic             sext,
  output logic             jal,
  output logic             mdusel,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             idex_hold,
  output logic             exmem_bubble,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] mdu_stalls
);

  logic       d_wreg, d_wmem, d_mdu;
  logic [1:0] d_pcs;
  logic       uses_rs, uses_rt;
  logic       lu_stall, busy, bubble, mul_issue;
  fwd_sel_t   fwd_a, fwd_b;

  always_comb begin
    d_wreg  = 1'b0;
    d_wmem  = 1'b0;
    d_mdu   = 1'b0;
    d_pcs   = PCS_SEQ;
    regrt   = 1'b0;
    m2reg   = 1'b0;
    shift   = 1'b0;
    aluimm  = 1'b0;
    sext    = 1'b0;
    jal     = 1'b0;
    aluc    = ALUC_ADD;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin d_wreg = 1'b1; aluc = ALUC_ADD; uses_rs = 1'b1; uses_rt = 1'b1; end
          FN_SUB: begin d_wreg = 1'b1; aluc = ALUC_SUB; uses_rs = 1'b1; uses_rt = 1'b1; end
          FN_AND: begin d_wreg = 1'b1; aluc = ALUC_AND; uses_rs = 1'b1; uses_rt = 1'b1; end
          FN_OR:  begin d_wreg = 1'b1; aluc = ALUC_OR;  uses_rs = 1'b1; uses_rt = 1'b1; end
          FN_XOR: begin d_wreg = 1'b1; aluc = ALUC_XOR; uses_rs = 1'b1; uses_rt = 1'b1; end
          FN_SLL: begin d_wreg = 1'b1; shift = 1'b1; aluc = ALUC_SLL; uses_rt = 1'b1; end
          FN_SRL: begin d_wreg = 1'b1; shift = 1'b1; aluc = ALUC_SRL; uses_rt = 1'b1; end
          FN_SRA: begin d_wreg = 1'b1; shift = 1'b1; aluc = ALUC_SRA; uses_rt = 1'b1; end
          FN_JR:  begin d_pcs = PCS_JR; uses_rs = 1'b1; end
          FN_MUL: begin
            d_wreg = 1'b1; d_mdu = 1'b1; aluc = ALUC_ADD;
            uses_rs = 1'b1; uses_rt = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        d_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1;
        aluc = ALUC_ADD; uses_rs = 1'b1;
      end
      OP_ANDI: begin d_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_AND; uses_rs = 1'b1; end
      OP_ORI:  begin d_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_OR;  uses_rs = 1'b1; end
      OP_XORI: begin d_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_XOR; uses_rs = 1'b1; end
      OP_LW: begin
        d_wreg = 1'b1; regrt = 1'b1; m2reg = 1'b1; aluimm = 1'b1; sext = 1'b1;
        aluc = ALUC_ADD; uses_rs = 1'b1;
      end
      OP_SW: begin
        d_wmem = 1'b1; aluimm = 1'b1; sext = 1'b1;
        aluc = ALUC_ADD; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        sext = 1'b1; aluc = ALUC_SUB; uses_rs = 1'b1; uses_rt = 1'b1;
        d_pcs = z ? PCS_BR : PCS_SEQ;
      end
      OP_BNE: begin
        sext = 1'b1; aluc = ALUC_SUB; uses_rs = 1'b1; uses_rt = 1'b1;
        d_pcs = z ? PCS_SEQ : PCS_BR;
      end
      OP_LUI: begin d_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; aluc = ALUC_LUI; end
      OP_J:   d_pcs = PCS_JMP;
      OP_JAL: begin d_wreg = 1'b1; jal = 1'b1; d_pcs = PCS_JMP; end
      default: ;
    endcase
  end

  function automatic fwd_sel_t fwd_pick(
    input logic [RA_W-1:0] src,
    input logic            e_w,
    input logic            e_m,
    input logic [RA_W-1:0] e_rn,
    input logic            m_w,
    input logic            m_m,
    input logic [RA_W-1:0] m_rn
  );
    if (e_w && !e_m && (e_rn != '0) && (e_rn == src))      return FWD_EXALU;
    else if (m_w && !m_m && (m_rn != '0) && (m_rn == src)) return FWD_MEMALU;
    else if (m_w && m_m && (m_rn != '0) && (m_rn == src))  return FWD_MEMDAT;
    else                                                   return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = fwd_pick(rs, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
    fwd_b = fwd_pick(rt, ewreg, em2reg, ern, mwreg, mm2reg, mrn);
  end

  assign fwda = fwd_a;
  assign fwdb = fwd_b;

  assign lu_stall = ewreg && em2reg && (ern != '0) &&
                    (((ern == rs) && uses_rs) || ((ern == rt) && uses_rt));

  // a load-use stall holds mul in ID; it issues on the first clean cycle
  assign mul_issue = d_mdu && !lu_stall && !busy;

  pipe_mdu_seq #(.MUL_LAT(MUL_LAT)) u_mdu_seq (
    .clock  (clock),
    .resetn (resetn),
    .start  (mul_issue),
    .busy   (busy)
  );

  assign bubble   = !resetn || busy || lu_stall;
  assign wreg     = d_wreg && !bubble;
  assign wmem     = d_wmem && !bubble;
  assign mdusel   = d_mdu && !bubble;
  assign pcsource = bubble ? PCS_SEQ : d_pcs;

  assign wpcir        = !resetn || (!busy && !lu_stall);
  assign idex_hold    = busy;
  assign exmem_bubble = busy;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lu_stalls  <= '0;
      mdu_stalls <= '0;
    end else begin
      if (lu_stall && !busy && !(&lu_stalls)) lu_stalls <= lu_stalls + CNT_W'(1);
      if (busy && !(&mdu_stalls))             mdu_stalls <= mdu_stalls + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_cu_hz.sv
// Directed bench for pipe_cu_hz: stimulus pushes expected outputs into a
// scoreboard queue, a negedge monitor pops and compares under a field mask.
module tb_pipe_cu_hz;

  localparam int RA_W = 5;

  logic            clock, resetn;
  logic [5:0]      op, func;
  logic [RA_W-1:0] rs, rt, ern, mrn;
  logic            z, ewreg, em2reg, mwreg, mm2reg;
  logic            wreg, wmem, regrt, m2reg, shift, aluimm, sext, jal, mdusel;
  logic [3:0]      aluc;
  logic [1:0]      pcsource, fwda, fwdb;
  logic            wpcir, idex_hold, exmem_bubble;
  logic [3:0]      lu_stalls, mdu_stalls;

  pipe_cu_hz #(.RA_W(RA_W), .MUL_LAT(4), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .rs(rs), .rt(rt), .z(z),
    .ewreg(ewreg), .em2reg(em2reg), .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn),
    .wreg(wreg), .wmem(wmem), .regrt(regrt), .m2reg(m2reg), .shift(shift),
    .aluimm(aluimm), .sext(sext), .jal(jal), .mdusel(mdusel), .aluc(aluc),
    .pcsource(pcsource), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
    .idex_hold(idex_hold), .exmem_bubble(exmem_bubble),
    .lu_stalls(lu_stalls), .mdu_stalls(mdu_stalls)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {wreg,wmem,regrt,m2reg,shift,aluimm,sext,jal,mdusel, aluc, pcsource,
  //  fwda, fwdb, wpcir,idex_hold,exmem_bubble, lu_stalls, mdu_stalls}
  logic [29:0] act;
  assign act = {wreg, wmem, regrt, m2reg, shift, aluimm, sext, jal, mdusel,
                aluc, pcsource, fwda, fwdb, wpcir, idex_hold, exmem_bubble,
                lu_stalls, mdu_stalls};

  localparam logic [29:0] F_DEC  = {9'h1FF, 21'h0};
  localparam logic [29:0] F_WW   = {2'b11, 28'h0};
  localparam logic [29:0] F_ALUC = {9'h0, 4'hF, 17'h0};
  localparam logic [29:0] F_PCS  = {13'h0, 2'b11, 15'h0};
  localparam logic [29:0] F_FWD  = {15'h0, 4'hF, 11'h0};
  localparam logic [29:0] F_CTL  = {19'h0, 3'b111, 8'h0};
  localparam logic [29:0] F_CNT  = {22'h0, 8'hFF};
  localparam logic [29:0] F_ALL  = F_DEC | F_ALUC | F_PCS | F_FWD | F_CTL | F_CNT;
  localparam logic [29:0] F_GATE = F_WW | F_PCS | F_CTL | F_CNT;

  localparam logic [8:0] D_ALU  = 9'b100000000;
  localparam logic [8:0] D_JAL  = 9'b100000010;
  localparam logic [8:0] D_SLL  = 9'b100010000;
  localparam logic [8:0] D_ADDI = 9'b101001100;
  localparam logic [8:0] D_BR   = 9'b000000100;
  localparam logic [8:0] D_MUL  = 9'b100000001;
  localparam logic [8:0] D_NONE = 9'b000000000;

  localparam logic [2:0] C_RUN  = 3'b100;
  localparam logic [2:0] C_STL  = 3'b000;
  localparam logic [2:0] C_BUSY = 3'b011;

  typedef struct {
    string       name;
    logic [29:0] exp;
    logic [29:0] msk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [29:0] mk(logic [8:0] d, logic [3:0] a, logic [1:0] p,
                                     logic [1:0] fa, logic [1:0] fb, logic [2:0] c,
                                     logic [3:0] lu, logic [3:0] md);
    return {d, a, p, fa, fb, c, lu, md};
  endfunction

  task automatic instr(logic [5:0] o, logic [5:0] f, int s, int t, logic zz);
    op = o; func = f; rs = RA_W'(s); rt = RA_W'(t); z = zz;
  endtask

  task automatic haz(logic ew, logic em, int en, logic mw, logic mm, int mn);
    ewreg = ew; em2reg = em; ern = RA_W'(en); mwreg = mw; mm2reg = mm; mrn = RA_W'(mn);
  endtask

  task automatic chk(string nm, logic [29:0] e, logic [29:0] m);
    exp_t x;
    x.name = nm; x.exp = e; x.msk = m;
    sb.push_back(x);
    @(posedge clock); #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if ((act & x.msk) !== (x.exp & x.msk)) begin
          errors++;
          $display("FAIL %s actual=%h expected=%h mask=%h", x.name,
                   act & x.msk, x.exp & x.msk, x.msk);
        end
      end
    end
  end

  initial begin : driver
    resetn = 1'b0;
    instr(6'b000011, 6'b0, 0, 0, 1'b0);
    haz(0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    chk("reset_state", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_RUN, 4'd0, 4'd0), F_GATE);

    resetn = 1'b1;
    chk("jal_decode", mk(D_JAL, 4'h0, 2'b11, 2'b00, 2'b00, C_RUN, 4'd0, 4'd0),
        F_DEC | F_PCS | F_CTL | F_CNT);

    instr(6'b000000, 6'b100000, 5, 7, 1'b0);
    chk("add_clean", mk(D_ALU, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd0, 4'd0), F_ALL);

    haz(1, 1, 5, 0, 0, 0);
    chk("load_use_add", mk(D_NONE, 4'b0000, 2'b00, 2'b00, 2'b00, C_STL, 4'd0, 4'd0), F_ALL);

    haz(0, 0, 0, 1, 1, 5);
    chk("fwd_memdat", mk(D_ALU, 4'b0000, 2'b00, 2'b11, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    instr(6'b000000, 6'b100010, 3, 4, 1'b0);
    haz(1, 0, 3, 1, 1, 3);
    chk("fwd_ex_prio", mk(D_ALU, 4'b0100, 2'b00, 2'b01, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    haz(1, 0, 0, 1, 1, 3);
    chk("fwd_ern_zero", mk(D_ALU, 4'b0100, 2'b00, 2'b11, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    haz(0, 0, 0, 1, 0, 4);
    chk("fwd_memalu_rt", mk(D_ALU, 4'b0100, 2'b00, 2'b00, 2'b10, C_RUN, 4'd1, 4'd0), F_ALL);

    instr(6'b000000, 6'b000000, 5, 2, 1'b0);
    haz(1, 1, 5, 0, 0, 0);
    chk("sll_no_rs_use", mk(D_SLL, 4'b0011, 2'b00, 2'b00, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    instr(6'b001000, 6'b0, 1, 5, 1'b0);
    chk("addi_no_rt_use", mk(D_ADDI, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd1, 4'd0),
        F_DEC | F_ALUC | F_PCS | F_CTL | F_CNT);

    haz(0, 0, 0, 0, 0, 0);
    instr(6'b000101, 6'b0, 1, 2, 1'b0);
    chk("bne_taken", mk(D_BR, 4'b0100, 2'b01, 2'b00, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    instr(6'b000101, 6'b0, 1, 2, 1'b1);
    chk("bne_not_taken", mk(D_BR, 4'b0100, 2'b00, 2'b00, 2'b00, C_RUN, 4'd1, 4'd0), F_ALL);

    instr(6'b000000, 6'b001000, 31, 0, 1'b0);
    chk("jr", mk(D_NONE, 4'h0, 2'b10, 2'b00, 2'b00, C_RUN, 4'd1, 4'd0),
        F_DEC | F_PCS | F_CTL | F_CNT);

    instr(6'b000100, 6'b0, 1, 2, 1'b1);
    haz(1, 1, 2, 0, 0, 0);
    chk("beq_lu_rt", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_STL, 4'd1, 4'd0), F_GATE);

    instr(6'b000000, 6'b011000, 5, 6, 1'b0);
    haz(1, 1, 5, 0, 0, 0);
    chk("mul_lu_held", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_STL, 4'd2, 4'd0), F_GATE);

    haz(0, 0, 0, 0, 0, 0);
    chk("mul_issue_T", mk(D_MUL, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd3, 4'd0), F_ALL);

    instr(6'b000000, 6'b100000, 9, 10, 1'b0);
    chk("mul_T1", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_BUSY, 4'd3, 4'd0), F_GATE);

    haz(1, 1, 9, 0, 0, 0);
    chk("mul_T2_busy_over_lu", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_BUSY, 4'd3, 4'd1), F_GATE);

    haz(0, 0, 0, 0, 0, 0);
    chk("mul_T3", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_BUSY, 4'd3, 4'd2), F_GATE);

    chk("mul_T4_normal", mk(D_ALU, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd3, 4'd3), F_ALL);

    instr(6'b000000, 6'b011000, 5, 6, 1'b0);
    chk("mul2_issue", mk(D_MUL, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd3, 4'd3), F_ALL);

    instr(6'b000000, 6'b100000, 9, 10, 1'b0);
    chk("mul2_T1", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_BUSY, 4'd3, 4'd3), F_GATE);

    resetn = 1'b0;
    chk("async_reset_abort", mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_RUN, 4'd0, 4'd0), F_GATE);

    resetn = 1'b1;
    chk("after_reset_idle", mk(D_ALU, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd0, 4'd0), F_ALL);

    instr(6'b000000, 6'b100000, 5, 7, 1'b0);
    haz(1, 1, 5, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("lu_sat_%0d", i),
          mk(D_NONE, 4'h0, 2'b00, 2'b00, 2'b00, C_STL, 4'((i > 15) ? 15 : i), 4'd0), F_GATE);
    end

    haz(0, 0, 0, 0, 0, 0);
    chk("lu_saturated", mk(D_ALU, 4'b0000, 2'b00, 2'b00, 2'b00, C_RUN, 4'd15, 4'd0), F_ALL);

    repeat (2) @(posedge clock);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
